reg_to_obi_bridge: RTL and testbench

- Register-interface responder to OBI initiator bridge; the reverse direction of the existing OBI-to-register path used by the always-on peripheral bus.
- Lets a reg-bus master (debug/config logic, external-peripheral slot, always-on control FSMs) issue single reads/writes into the OBI system bus (RAM banks, peripheral subsystem).
- One outstanding transaction, registered OBI request, optional response timeout with error reporting.

---
 rtl/obi_pkg.sv | 16 +
 rtl/reg_pkg.sv | 16 +
 rtl/reg_to_obi_bridge_pkg.sv | 12 +
 rtl/reg_to_obi_bridge.sv | 126 ++++++++++++
 tb/tb_reg_to_obi_bridge.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response structs
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// File: rtl/reg_pkg.sv
// reg_pkg: register-interface request/response structs
package reg_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;
endpackage

// File: rtl/reg_to_obi_bridge_pkg.sv
// reg_to_obi_bridge_pkg: bridge FSM states and default timeout
package reg_to_obi_bridge_pkg;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RESP,
    DONE,
    DRAIN
  } state_e;
endpackage

// File: rtl/reg_to_obi_bridge.sv
// reg_to_obi_bridge: reg-bus responder issuing single OBI transactions, one outstanding,
// with an optional rvalid timeout that reports error and drains the late response.
module reg_to_obi_bridge
  import reg_to_obi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  reg_pkg::reg_req_t  reg_req_i,
  output reg_pkg::reg_rsp_t  reg_rsp_o,
  output obi_pkg::obi_req_t  obi_req_o,
  input  obi_pkg::obi_resp_t obi_resp_i,
  output logic               timeout_o
);
  state_e            state_q, state_d;
  obi_pkg::obi_req_t obi_q, obi_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              timeout_q, timeout_d;
  logic              drain_q, drain_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              expired;

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    obi_d     = obi_q;
    ready_d   = 1'b0;
    timeout_d = 1'b0;
    error_d   = error_q;
    rdata_d   = rdata_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: if (reg_req_i.valid) begin
        obi_d.we    = reg_req_i.write;
        obi_d.addr  = reg_req_i.addr;
        obi_d.wdata = reg_req_i.wdata;
        obi_d.be    = reg_req_i.write ? reg_req_i.wstrb : 4'hF;
        // a write with no byte enables completes locally without touching the bus
        if (reg_req_i.write && reg_req_i.wstrb == 4'h0) begin
          ready_d = 1'b1;
          error_d = 1'b0;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          obi_d.req = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: if (obi_resp_i.gnt) begin
        obi_d.req = 1'b0;
        cnt_d     = '0;
        state_d   = RESP;
      end
      RESP: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (obi_resp_i.rvalid) begin
          rdata_d = obi_q.we ? '0 : obi_resp_i.rdata;
          error_d = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (expired) begin
          rdata_d   = '0;
          error_d   = 1'b1;
          ready_d   = 1'b1;
          timeout_d = 1'b1;
          drain_d   = 1'b1;
          state_d   = DONE;
        end
      end
      // a late rvalid landing right in DONE already settles the drain
      DONE: if (drain_q && obi_resp_i.rvalid) begin
        drain_d = 1'b0;
        state_d = IDLE;
      end else begin
        state_d = drain_q ? DRAIN : IDLE;
      end
      DRAIN: if (obi_resp_i.rvalid) begin
        drain_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      obi_q     <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      drain_q   <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      obi_q     <= obi_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      drain_q   <= drain_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign obi_req_o       = obi_q;
  assign reg_rsp_o.ready = ready_q;
  assign reg_rsp_o.rdata = rdata_q;
  assign reg_rsp_o.error = error_q;
  assign timeout_o       = timeout_q;

  a_gnt_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(state_q == ADDR && obi_resp_i.gnt && obi_resp_i.rvalid))
    else $error("gnt and rvalid together in ADDR");

  a_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(obi_resp_i.rvalid && (state_q == IDLE || (state_q == DONE && !drain_q))))
    else $warning("unexpected rvalid discarded");
endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// tb_reg_to_obi_bridge: directed transactions; expected per-cycle outputs are scheduled
// from transaction latencies, then compared against the DUT every cycle.
module tb_reg_to_obi_bridge;
  localparam int T = 8;
  localparam int N = 512;
  localparam int NV = 12;

  typedef struct {
    bit        rst;
    bit        wr;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  strb;
    int        gdly;
    int        rdly;
    int        late;
    bit [31:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  reg_pkg::reg_req_t  reg_req;
  reg_pkg::reg_rsp_t  reg_rsp;
  obi_pkg::obi_req_t  obi_req;
  obi_pkg::obi_resp_t obi_resp;
  logic timeout;
  int checks = 0;
  int errors = 0;
  int ncyc;

  vec_t vt [NV];
  int   acc [NV];
  int   gnt [NV];
  int   rdy [NV];
  int   late_rv [NV];

  bit        s_rst [N];
  bit        s_valid [N];
  bit        s_wr [N];
  bit [31:0] s_addr [N];
  bit [31:0] s_wdata [N];
  bit [3:0]  s_strb [N];
  bit        s_gnt [N];
  bit        s_rvalid [N];
  bit [31:0] s_rdata [N];

  bit        e_ready [N];
  bit [31:0] e_rdata [N];
  bit        e_error [N];
  bit        e_timeout [N];
  bit        e_req [N];
  bit        e_we [N];
  bit [3:0]  e_be [N];
  bit [31:0] e_addr [N];
  bit [31:0] e_wdata [N];

  always #5 clk = ~clk;

  reg_to_obi_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .reg_req_i(reg_req),
    .reg_rsp_o(reg_rsp),
    .obi_req_o(obi_req),
    .obi_resp_i(obi_resp),
    .timeout_o(timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  function automatic void set_master(input int a, input int b, input vec_t v);
    for (int c = a; c <= b; c++) begin
      s_valid[c] = 1'b1;
      s_wr[c]    = v.wr;
      s_addr[c]  = v.addr;
      s_wdata[c] = v.wdata;
      s_strb[c]  = v.strb;
    end
  endfunction

  // Each transaction: accepted when the bridge is idle, req from accept+1 through the
  // grant cycle, ready one cycle after rvalid, or T+1 cycles after grant on timeout.
  function automatic void build();
    int t, idle, a, g, rc, rv;
    for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
    t = 4;
    idle = 4;
    for (int i = 0; i < NV; i++) begin
      a = (t > idle) ? t : idle;
      acc[i] = a;
      if (vt[i].wr && vt[i].strb == 4'h0) begin
        rdy[i] = a + 1;
        set_master(t, rdy[i], vt[i]);
        e_ready[rdy[i]] = 1'b1;
        t = rdy[i] + 1;
        idle = t;
      end else begin
        g = a + 1 + vt[i].gdly;
        gnt[i] = g;
        s_gnt[g] = 1'b1;
        for (int c = a + 1; c <= g; c++) begin
          e_req[c]   = 1'b1;
          e_we[c]    = vt[i].wr;
          e_be[c]    = vt[i].wr ? vt[i].strb : 4'hF;
          e_addr[c]  = vt[i].addr;
          e_wdata[c] = vt[i].wdata;
        end
        if (vt[i].rst) begin
          rc = g + 2;
          set_master(t, rc - 1, vt[i]);
          s_rst[rc] = 1'b1;
          s_rst[rc + 1] = 1'b1;
          s_rvalid[rc + 2] = 1'b1;
          s_rdata[rc + 2] = vt[i].rdata;
          rdy[i] = -1;
          t = rc + 3;
          idle = t;
        end else if (vt[i].rdly > 0) begin
          rv = g + vt[i].rdly;
          s_rvalid[rv] = 1'b1;
          s_rdata[rv] = vt[i].rdata;
          rdy[i] = rv + 1;
          set_master(t, rdy[i], vt[i]);
          e_ready[rdy[i]] = 1'b1;
          e_rdata[rdy[i]] = vt[i].wr ? 32'h0 : vt[i].rdata;
          t = rdy[i] + 1;
          idle = t;
        end else begin
          rdy[i] = g + T + 1;
          set_master(t, rdy[i], vt[i]);
          e_ready[rdy[i]] = 1'b1;
          e_error[rdy[i]] = 1'b1;
          e_timeout[rdy[i]] = 1'b1;
          late_rv[i] = g + vt[i].late;
          s_rvalid[late_rv[i]] = 1'b1;
          s_rdata[late_rv[i]] = vt[i].rdata;
          t = rdy[i] + 1;
          idle = (late_rv[i] + 1 > t) ? late_rv[i] + 1 : t;
        end
      end
    end
    ncyc = t + 4;
  endfunction

  initial begin
    reg_req = '0;
    obi_resp = '0;
    vt[0] = '{1'b0, 1'b0, 32'h2000_0010, 32'h0, 4'h0, 0, 1, 0, 32'hDEAD_BEEF};
    vt[1] = '{1'b0, 1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 5, 1, 0, 32'hFFFF_FFFF};
    vt[2] = '{1'b0, 1'b0, 32'h2000_0100, 32'h0, 4'h0, 0, 0, 20, 32'hA5A5_A5A5};
    vt[3] = '{1'b0, 1'b0, 32'h2000_0104, 32'h0, 4'h0, 1, 3, 0, 32'h0BAD_F00D};
    vt[4] = '{1'b0, 1'b1, 32'h2000_0200, 32'hCAFE_0000, 4'h0, 0, 0, 0, 32'h0};
    vt[5] = '{1'b0, 1'b1, 32'h2000_0208, 32'h8765_4321, 4'b1100, 2, T, 0, 32'h5555_5555};
    vt[6] = '{1'b1, 1'b0, 32'h2000_0300, 32'h0, 4'h0, 0, 0, 0, 32'h7777_7777};
    vt[7] = '{1'b0, 1'b0, 32'h2000_0304, 32'h0, 4'h0, 0, 2, 0, 32'h600D_CAFE};
    for (int i = 0; i < 4; i++)
      vt[8 + i] = '{1'b0, 1'b0, 32'h2000_1000 + 32'(4 * i), 32'h0, 4'h0, 0, 1, 0, 32'h1111_0000 + 32'(i)};
    build();
    if (ncyc >= N) begin
      $display("FAIL schedule: %0d cycles exceeds %0d", ncyc, N);
      $fatal(1, "schedule too long");
    end
    chk("pin_read_latency", 32'(rdy[0] - acc[0]), 32'd3, -1);
    chk("pin_read_rdata", e_rdata[rdy[0]], 32'hDEAD_BEEF, -1);
    chk("pin_write_after_gnt", 32'(rdy[1] - gnt[1]), 32'd2, -1);
    chk("pin_write_gnt_wait", 32'(gnt[1] - acc[1]), 32'd6, -1);
    chk("pin_write_rdata", e_rdata[rdy[1]], 32'h0, -1);
    chk("pin_timeout_after_gnt", 32'(rdy[2] - gnt[2]), 32'd9, -1);
    chk("pin_drain_block", 32'(acc[3] - gnt[2]), 32'd21, -1);
    chk("pin_zero_strobe", 32'(rdy[4] - acc[4]), 32'd1, -1);
    chk("pin_b2b_spacing", 32'(rdy[9] - rdy[8]), 32'd4, -1);
    fork
      for (int c = 0; c < ncyc; c++) begin
        @(posedge clk);
        #1;
        rst_n          = !s_rst[c];
        reg_req.valid  = s_valid[c];
        reg_req.write  = s_wr[c];
        reg_req.addr   = s_addr[c];
        reg_req.wdata  = s_wdata[c];
        reg_req.wstrb  = s_strb[c];
        obi_resp.gnt    = s_gnt[c];
        obi_resp.rvalid = s_rvalid[c];
        obi_resp.rdata  = s_rdata[c];
      end
      for (int c = 0; c < ncyc; c++) begin
        @(posedge clk);
        @(negedge clk);
        chk("ready", 32'(reg_rsp.ready), 32'(e_ready[c]), c);
        chk("timeout", 32'(timeout), 32'(e_timeout[c]), c);
        chk("req", 32'(obi_req.req), 32'(e_req[c]), c);
        if (e_ready[c] || s_rst[c]) begin
          chk("rdata", reg_rsp.rdata, e_rdata[c], c);
          chk("error", 32'(reg_rsp.error), 32'(e_error[c]), c);
        end
        if (e_req[c] || s_rst[c]) begin
          chk("we", 32'(obi_req.we), 32'(e_we[c]), c);
          chk("be", 32'(obi_req.be), 32'(e_be[c]), c);
          chk("addr", obi_req.addr, e_addr[c], c);
          chk("wdata", obi_req.wdata, e_wdata[c], c);
        end
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
